d_ip_bus_master: RTL and testbench



---
 rtl/d_ip_bus_pkg.sv | 20 ++
 rtl/d_ip_sync_fifo.sv | 55 +++++
 rtl/d_ip_bus_master.sv | 144 ++++++++++++++
 tb/tb_d_ip_bus_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_ip_bus_pkg.sv
// Shared types and default bus widths for the d_ip register bus family.
package d_ip_bus_pkg;

    localparam int unsigned BUS_ADDR_W = 6;
    localparam int unsigned BUS_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } bus_state_t;

    typedef struct packed {
        logic                  write;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/d_ip_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
module d_ip_sync_fifo #(
    parameter int unsigned WIDTH = 15,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_b_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    // Pointers wrap naturally; count tracks simultaneous push/pop.
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, written on accepted push.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/d_ip_bus_master.sv
// Register-bus initiator: queues host requests, issues one bus access each,
// returns read data on a valid/ready response channel.
module d_ip_bus_master
    import d_ip_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = BUS_ADDR_W,
    parameter int unsigned DATA_W     = BUS_DATA_W,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic              mod_en,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy
);

    // FIFO entries use the bus_req_t field order {write, addr, wdata}, sized
    // by this instance's parameters rather than the package defaults.
    localparam int unsigned REQ_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    bus_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic              mod_en_q, mod_en_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              fifo_pop, fifo_full, fifo_empty;
    logic [REQ_W-1:0]  fifo_head;
    logic [FCNT_W-1:0] fifo_count;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    d_ip_sync_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_b_i     (rst_b),
        .push_i      (req_valid),
        .push_data_i ({req_write, req_addr, req_wdata}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign head_write = fifo_head[REQ_W-1];
    assign head_addr  = fifo_head[DATA_W +: ADDR_W];
    assign head_wdata = fifo_head[DATA_W-1:0];

    assign req_ready = !fifo_full;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign addr      = addr_q;
    assign wr_en     = wr_en_q;
    assign mod_en    = mod_en_q;
    assign wdata     = wdata_q;
    assign busy      = (fifo_count != '0) || (state_q != IDLE);

    // State, latency counter and registered bus/response outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            mod_en_q    <= 1'b0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            mod_en_q    <= mod_en_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state logic; bus outputs are computed one cycle early so the
    // ACCESS cycle sees them straight from registers. The request register
    // is the bus output register itself (wr_en_q tells ACCESS read/write).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = '0;
        wr_en_d     = 1'b0;
        mod_en_d    = 1'b0;
        wdata_d     = '0;
        rsp_rdata_d = rsp_rdata_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mod_en_d = 1'b1;
                    wr_en_d  = head_write;
                    addr_d   = head_addr;
                    wdata_d  = head_write ? head_wdata : '0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (wr_en_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    rsp_rdata_d = rdata;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_d_ip_bus_master.sv
// Directed bench for d_ip_bus_master with a bus-access/response scoreboard.
// Two instances share the host inputs: RD_LAT=1 (fully scoreboarded) and
// RD_LAT=3 (checked directly on read latency and reset behaviour).
`timescale 1ns/1ps
module tb_d_ip_bus_master;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_b, req_valid, req_write, rsp_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          req_ready1, rsp_valid1, wr_en1, mod_en1, busy1;
    logic [DW-1:0] rsp_rdata1, wdata1, rdata1;
    logic [AW-1:0] addr1;
    logic          req_ready3, rsp_valid3, wr_en3, mod_en3, busy3;
    logic [DW-1:0] rsp_rdata3, wdata3, rdata3;
    logic [AW-1:0] addr3;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    acc_t acc_q[$];
    logic [DW-1:0] rsp_q[$];
    int   acc_cyc[$];

    d_ip_bus_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1),
        .addr(addr1), .wr_en(wr_en1), .mod_en(mod_en1), .wdata(wdata1),
        .rdata(rdata1), .busy(busy1)
    );

    d_ip_bus_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .FIFO_DEPTH(DEPTH)) u_dut3 (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready3),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3),
        .addr(addr3), .wr_en(wr_en3), .mod_en(mod_en3), .wdata(wdata3),
        .rdata(rdata3), .busy(busy3)
    );

    function automatic logic [DW-1:0] periph_val(input logic [AW-1:0] a);
        if (a == 6'h10) return 8'h5C;
        return {2'b00, a} ^ 8'hA0;
    endfunction

    // Peripheral models: read data is valid only in the cycle it is sampled.
    logic [DW:0] p1 = '0;
    logic [DW:0] p3a = '0, p3b = '0, p3c = '0;
    always @(posedge clk) begin
        p1  <= (mod_en1 && !wr_en1) ? {1'b1, periph_val(addr1)} : '0;
        p3a <= (mod_en3 && !wr_en3) ? {1'b1, periph_val(addr3)} : '0;
        p3b <= p3a;
        p3c <= p3b;
    end
    assign rdata1 = p1[DW]  ? p1[DW-1:0]  : 8'hEE;
    assign rdata3 = p3c[DW] ? p3c[DW-1:0] : 8'hEE;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor for the RD_LAT=1 instance.
    always @(negedge clk) begin
        acc_t o;
        acc_t e;
        logic [DW-1:0] r;
        if (rst_b) begin
            o = {wr_en1, addr1, wdata1};
            if (mod_en1) begin
                acc_cyc.push_back(cyc);
                checks++;
                assert (acc_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_access: observed %0h expected none", o);
                end
                if (acc_q.size() != 0) begin
                    e = acc_q.pop_front();
                    checks++;
                    assert (o === e) else begin
                        errors++;
                        $error("FAIL access_fields: observed %0h expected %0h", o, e);
                    end
                end
            end else begin
                checks++;
                assert (o === '0) else begin
                    errors++;
                    $error("FAIL idle_bus_zero: observed %0h expected 0", o);
                end
            end
            if (rsp_valid1 && rsp_ready) begin
                checks++;
                assert (rsp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_rsp: observed %0h expected none", rsp_rdata1);
                end
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    checks++;
                    assert (rsp_rdata1 === r) else begin
                        errors++;
                        $error("FAIL rsp_data: observed %0h expected %0h", rsp_rdata1, r);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int unsigned n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready1 && n < 50) begin tick(); n++; end
        chk("accept_timeout", 32'(req_ready1), 32'd1);
        tick();
        acc_q.push_back({w, a, w ? d : 8'h00});
        if (!w) rsp_q.push_back(periph_val(a));
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((busy1 || busy3) && n < 100) begin tick(); n++; end
        chk("drain_busy", 32'({busy1, busy3}), 32'd0);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        acc_q.delete();
        rsp_q.delete();
    endtask

    initial begin
        int base;
        rst_b = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready1), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata1), 32'd0);
        chk("rst_bus", 32'({addr1, wr_en1, mod_en1, wdata1}), 32'd0);
        chk("rst_busy", 32'({busy1, busy3}), 32'd0);
        chk("rst_mod_en3", 32'(mod_en3), 32'd0);
        rst_b = 1'b1;
        repeat (4) begin tick(); chk("post_rst_idle", 32'({mod_en1, mod_en3}), 32'd0); end

        // Single write 0xA5 -> 0x03
        send(1'b1, 6'h03, 8'hA5);
        chk("wr_not_yet", 32'(mod_en1), 32'd0);
        tick();
        chk("wr_mod_en", 32'(mod_en1), 32'd1);
        chk("wr_wr_en", 32'(wr_en1), 32'd1);
        chk("wr_addr", 32'(addr1), 32'h03);
        chk("wr_wdata", 32'(wdata1), 32'hA5);
        tick();
        chk("wr_one_cycle", 32'(mod_en1), 32'd0);
        repeat (3) begin tick(); chk("wr_no_rsp", 32'({rsp_valid1, rsp_valid3}), 32'd0); end
        drain();

        // Read 0x10 for RD_LAT 1 and 3
        send(1'b0, 6'h10, 8'hFF);
        tick();
        chk("rd_access1", 32'({mod_en1, wr_en1, addr1, wdata1}), 32'({1'b1, 1'b0, 6'h10, 8'h00}));
        chk("rd_access3", 32'({mod_en3, wr_en3, addr3, wdata3}), 32'({1'b1, 1'b0, 6'h10, 8'h00}));
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("rd_valid_lat1", 32'(rsp_valid1), 32'(k == 2));
            chk("rd_valid_lat3", 32'(rsp_valid3), 32'(k == 4));
            if (k == 2) chk("rd_data_lat1", 32'(rsp_rdata1), 32'h5C);
            if (k == 4) chk("rd_data_lat3", 32'(rsp_rdata3), 32'h5C);
        end
        drain();

        // Back-to-back write burst: accesses every 2 cycles, in order
        base = acc_cyc.size();
        for (int i = 0; i < 5; i++) send(1'b1, AW'(8 + i), DW'(8'h30 + i));
        drain();
        chk("burst_count", 32'(acc_cyc.size() - base), 32'd5);
        for (int i = 1; i < 5; i++)
            chk("burst_spacing", 32'(acc_cyc[base+i] - acc_cyc[base+i-1]), 32'd2);

        // Read held under back-pressure with writes queued behind it
        rsp_ready = 1'b0;
        send(1'b0, 6'h21, 8'h00);
        for (int i = 0; i < 4; i++) send(1'b1, AW'(6'h28 + i), DW'(8'h70 + i));
        chk("bp_full", 32'(req_ready1), 32'd0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h2C; req_wdata = 8'h74;
        for (int i = 0; i < 10; i++) begin
            chk("bp_ready_low", 32'(req_ready1), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid1), 32'd1);
            chk("bp_rsp_rdata", 32'(rsp_rdata1), 32'h81);
            chk("bp_no_access", 32'(mod_en1), 32'd0);
            tick();
        end
        chk("bp_rsp_still", 32'(rsp_valid1), 32'd1);
        rsp_ready = 1'b1;
        tick();
        chk("bp_after_rsp", 32'({rsp_valid1, mod_en1, req_ready1}), 32'd0);
        tick();
        chk("bp_first_wr", 32'({mod_en1, req_ready1}), 32'b11);
        tick();
        acc_q.push_back({1'b1, 6'h2C, 8'h74});
        req_valid = 1'b0;
        base = acc_cyc.size() - 1;
        drain();
        chk("bp_wr_count", 32'(acc_cyc.size() - base), 32'd5);
        for (int i = 1; i < 5; i++)
            chk("bp_spacing", 32'(acc_cyc[base+i] - acc_cyc[base+i-1]), 32'd2);

        // Reset during WAIT (RD_LAT=3 instance) with 3 requests queued
        rsp_ready = 1'b0;
        send(1'b0, 6'h10, 8'h00);
        for (int i = 0; i < 3; i++) send(1'b1, AW'(6'h30 + i), DW'(8'h90 + i));
        chk("pre_rst_rsp1", 32'(rsp_valid1), 32'd1);
        chk("pre_rst_busy3", 32'({busy3, rsp_valid3}), 32'b10);
        #2;
        do_reset();
        #1;
        chk("mid_rst_bus", 32'({mod_en1, mod_en3, rsp_valid1, rsp_valid3}), 32'd0);
        chk("mid_rst_busy", 32'({busy1, busy3}), 32'd0);
        chk("mid_rst_rdata", 32'(rsp_rdata1), 32'd0);
        chk("mid_rst_ready", 32'({req_ready1, req_ready3}), 32'b11);
        tick();
        rsp_ready = 1'b1;
        rst_b = 1'b1;
        repeat (4) begin
            tick();
            chk("post_rst_no_stale", 32'({mod_en1, mod_en3, busy1, busy3}), 32'd0);
        end

        // Reset during an access cycle drops mod_en at once
        send(1'b1, 6'h3F, 8'h11);
        tick();
        chk("acc_before_rst", 32'(mod_en1), 32'd1);
        #2;
        do_reset();
        #1;
        chk("acc_rst_drop", 32'({mod_en1, wr_en1, addr1, wdata1}), 32'd0);
        tick();
        rst_b = 1'b1;
        repeat (3) begin tick(); chk("acc_rst_quiet", 32'({mod_en1, busy1}), 32'd0); end

        chk("sb_acc_empty", 32'(acc_q.size()), 32'd0);
        chk("sb_rsp_empty", 32'(rsp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
